// File: rtl/jit_template_emitter.sv
// ---------------------------------------------------------------------------
// jit_template_emitter
//
// Purpose:
//   Writable opcode-template store for the JIT code generator. A request
//   names a template index. The block looks up that template's descriptor
//   (start address and length) and streams the template's instruction words
//   to the code-buffer writer, flagging the last word. Words and descriptors
//   are loaded at runtime through the cfg_* port while the block is idle.
//
// Optional feature (macro JIT_EMIT_PATCH_EN):
//   When defined, a descriptor with patch_en=1 ORs the request's 12-bit
//   immediate into the word at offset patch_off of the template. When the
//   macro is undefined, patch fields and req_imm are ignored and words are
//   emitted verbatim.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   emit request handshake; req_idx selects template,
//                         req_imm is the patch immediate
//   out_valid/out_ready   word stream handshake; out_data is the word,
//                         out_last marks the final word of the template
//   err_empty             1-cycle pulse: accepted index has length 0
//   cfg_we/cfg_sel        config write strobe; sel 0 = word store,
//                         sel 1 = descriptor table
//   cfg_addr/cfg_data     word address or descriptor index, and payload;
//                         descriptor = {.., patch_off, patch_en, len, start}
//   cfg_err               1-cycle pulse: config write dropped (block busy)
//   dbg_state             current FSM state (IDLE=0, LOAD=1, EMIT=2)
//
// Handshake rule (both the req_* and out_* ports): a transfer happens on a
// rising clock edge where valid and ready are both 1. A source holding
// valid=1 keeps its payload stable until the transfer; ready may change
// freely and never depends on the transfer having already happened.
// ---------------------------------------------------------------------------
module jit_template_emitter #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 7,
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [IDX_W-1:0]  req_idx,
   input  logic [11:0]       req_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              err_empty,
   input  logic              cfg_we,
   input  logic              cfg_sel,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [DATA_W-1:0] cfg_data,
   output logic              cfg_err,
   output logic [1:0]        dbg_state
);

   localparam int N_DESC  = 2 ** IDX_W;
   localparam int N_WORDS = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_EMIT = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Storage: word store is never reset; only descriptor lengths are, so an
   // unconfigured index reads as an empty template.
   logic [DATA_W-1:0] word_mem   [N_WORDS];
   logic [ADDR_W-1:0] desc_start [N_DESC];
   logic [LEN_W-1:0]  desc_len   [N_DESC];

   // Per-request context
   logic [ADDR_W-1:0] start_q;
   logic [ADDR_W-1:0] rd_ptr_q;     // address of the word after the one shown
   logic [LEN_W-1:0]  cnt_q;        // words still to hand over, incl. current
   logic [LEN_W-1:0]  off_q;        // template offset of the word at rd_ptr_q
   logic [DATA_W-1:0] out_data_q;
   logic              err_empty_q;
   logic              cfg_err_q;

   logic              accept;
   logic              cfg_wr;
   logic [IDX_W-1:0]  cfg_idx;
   logic [ADDR_W-1:0] fetch_addr;
   logic [LEN_W-1:0]  fetch_off;
   logic [DATA_W-1:0] patch_mask;
   logic [DATA_W-1:0] fetch_word;

   assign cfg_idx = cfg_addr[IDX_W-1:0];
   assign cfg_wr  = cfg_we && (state_q == S_IDLE);
   assign accept  = req_valid && req_ready;

   // ------------------------------------------------------------------
   // FSM next state and handshake outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A config write owns the cycle; rst_n keeps ready low in reset.
            req_ready = rst_n && !cfg_we;
            if (req_valid && req_ready && (desc_len[req_idx] != '0))
               state_d = S_LOAD;
         end
         S_LOAD: begin
            state_d = S_EMIT;
         end
         S_EMIT: begin
            out_valid = 1'b1;
            out_last  = (cnt_q == LEN_W'(1));
            if (out_ready && (cnt_q == LEN_W'(1)))
               state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Word fetch: in LOAD the first word is read from start; in EMIT the
   // word after the one on out_data is fetched so a handshake can refill
   // out_data on the same edge without a bubble.
   // ------------------------------------------------------------------
   assign fetch_addr = (state_q == S_LOAD) ? start_q : rd_ptr_q;
   assign fetch_off  = (state_q == S_LOAD) ? '0 : off_q;

`ifdef JIT_EMIT_PATCH_EN
   logic              desc_pen  [N_DESC];
   logic [LEN_W-1:0]  desc_poff [N_DESC];
   logic              pen_q;
   logic [LEN_W-1:0]  poff_q;
   logic [11:0]       imm_q;
   logic              unused_cfg_hi;

   always_ff @(posedge clk) begin
      if (cfg_wr && cfg_sel) begin
         desc_pen[cfg_idx]  <= cfg_data[ADDR_W+LEN_W];
         desc_poff[cfg_idx] <= cfg_data[ADDR_W+LEN_W+1 +: LEN_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pen_q  <= 1'b0;
         poff_q <= '0;
         imm_q  <= '0;
      end else if (accept) begin
         pen_q  <= desc_pen[req_idx];
         poff_q <= desc_poff[req_idx];
         imm_q  <= req_imm;
      end
   end

   // Offsets only run 0..len-1, so patch_off >= len never matches.
   assign patch_mask = (pen_q && (fetch_off == poff_q)) ?
                       {{(DATA_W-12){1'b0}}, imm_q} : '0;
   assign unused_cfg_hi = ^cfg_data[DATA_W-1:ADDR_W+2*LEN_W+1];
`else
   logic unused_patch;
   assign patch_mask   = '0;
   assign unused_patch = ^{req_imm, fetch_off, cfg_data[DATA_W-1:ADDR_W+LEN_W]};
`endif

   assign fetch_word = word_mem[fetch_addr] | patch_mask;

   // ------------------------------------------------------------------
   // Configuration storage (writes only land while idle)
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (cfg_wr && !cfg_sel)
         word_mem[cfg_addr] <= cfg_data;
      if (cfg_wr && cfg_sel)
         desc_start[cfg_idx] <= cfg_data[ADDR_W-1:0];
   end

   // ------------------------------------------------------------------
   // State, descriptor lengths and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         start_q     <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         off_q       <= '0;
         out_data_q  <= '0;
         err_empty_q <= 1'b0;
         cfg_err_q   <= 1'b0;
         for (int i = 0; i < N_DESC; i++)
            desc_len[i] <= '0;
      end else begin
         state_q     <= state_d;
         err_empty_q <= accept && (desc_len[req_idx] == '0);
         cfg_err_q   <= cfg_we && (state_q != S_IDLE);

         if (cfg_wr && cfg_sel)
            desc_len[cfg_idx] <= cfg_data[ADDR_W +: LEN_W];

         if (accept) begin
            start_q <= desc_start[req_idx];
            cnt_q   <= desc_len[req_idx];
         end

         if (state_q == S_LOAD) begin
            out_data_q <= fetch_word;
            rd_ptr_q   <= start_q + ADDR_W'(1);   // wraps mod 2**ADDR_W
            off_q      <= LEN_W'(1);
         end else if ((state_q == S_EMIT) && out_ready) begin
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q != LEN_W'(1)) begin
               out_data_q <= fetch_word;
               rd_ptr_q   <= rd_ptr_q + ADDR_W'(1);
               off_q      <= off_q + LEN_W'(1);
            end
         end
      end
   end

   assign out_data  = out_data_q;
   assign err_empty = err_empty_q;
   assign cfg_err   = cfg_err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_jit_template_emitter.sv
module tb_jit_template_emitter;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 7;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              req_valid, req_ready;
  logic [IDX_W-1:0]  req_idx;
  logic [11:0]       req_imm;
  logic              out_valid, out_ready, out_last;
  logic [DATA_W-1:0] out_data;
  logic              err_empty;
  logic              cfg_we, cfg_sel;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_err;
  logic [1:0]        dbg_state;

  jit_template_emitter #(
    .DATA_W(DATA_W), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx), .req_imm(req_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err_empty(err_empty),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_word  [256];
  logic [7:0]        m_start [128];
  logic [3:0]        m_len   [128];
  logic              m_pen   [128];
  logic [3:0]        m_poff  [128];
  logic [DATA_W-1:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] desc(input logic [7:0] start, input logic [3:0] len,
                                             input logic pen, input logic [3:0] poff);
    return {15'b0, poff, pen, len, start};
  endfunction

  // Template = len consecutive words from start (address wraps at 256),
  // with the optional immediate OR'd into word patch_off.
  task automatic build_expect(input logic [6:0] idx, input logic [11:0] imm);
    logic [7:0]        a;
    logic [DATA_W-1:0] w;
    exp_q.delete();
    for (int k = 0; k < int'(m_len[idx]); k++) begin
      a = m_start[idx] + 8'(k);
      w = m_word[a];
`ifdef JIT_EMIT_PATCH_EN
      if (m_pen[idx] && (k == int'(m_poff[idx]))) w = w | {20'b0, imm};
`endif
      exp_q.push_back(w);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at a negedge.
  task automatic cfg_write(input logic sel, input logic [7:0] addr, input logic [DATA_W-1:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
    #1 check("cfg_blocks_req_ready", req_ready, 0);
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_err_idle", cfg_err, 0);
    if (!sel) m_word[addr] = data;
    else begin
      m_start[addr[6:0]] = data[7:0];
      m_len[addr[6:0]]   = data[11:8];
      m_pen[addr[6:0]]   = data[12];
      m_poff[addr[6:0]]  = data[16:13];
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 3 cycles on word 1.
  // inject: drive a dropped word-store write on the first EMIT cycle.
  task automatic do_req(input logic [6:0] idx, input logic [11:0] imm, input int mode,
                        input logic inject, input logic [7:0] inj_addr);
    int   n, cyc, word_i, stall_cnt;
    logic rdy;
    build_expect(idx, imm);
    n = exp_q.size();
    req_valid = 1'b1; req_idx = idx; req_imm = imm;
    #1 check("req_ready_idle", req_ready, 1);
    @(negedge clk);                       // T+1
    req_valid = 1'b0;
    check("t1_no_valid", out_valid, 0);
    check("err_empty", err_empty, (n == 0));
    if (n == 0) begin
      @(negedge clk);
      check("err_empty_pulse_end", err_empty, 0);
      check("empty_no_valid", out_valid, 0);
      check("empty_req_ready", req_ready, 1);
      return;
    end
    check("load_req_ready", req_ready, 0);
    @(negedge clk);                       // T+2: first word must be shown
    cyc = 0; word_i = 0; stall_cnt = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      check("out_valid", out_valid, 1);
      check("out_data", out_data, exp_q[0]);
      check("out_last", out_last, (exp_q.size() == 1));
      check("cfg_err_emit", cfg_err, (inject && cyc == 1));
      if (inject && cyc == 0) begin
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = inj_addr; cfg_data = ~m_word[inj_addr];
      end else cfg_we = 1'b0;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 2) != 0);
        default: begin
          rdy = !(word_i == 1 && stall_cnt < 3);
          if (!rdy) stall_cnt++;
        end
      endcase
      out_ready = rdy;
      @(negedge clk);
      if (rdy) begin
        void'(exp_q.pop_front());
        word_i++;
      end
      cyc++;
    end
    cfg_we = 1'b0;
    out_ready = 1'b0;
    check("stream_done", exp_q.size(), 0);
    check("end_no_valid", out_valid, 0);
    check("end_no_last", out_last, 0);
    check("end_req_ready", req_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_idx = '0; req_imm = '0;
    out_ready = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
    for (int i = 0; i < 256; i++) m_word[i] = 'x;
    for (int i = 0; i < 128; i++) begin
      m_start[i] = '0; m_len[i] = '0; m_pen[i] = 1'b0; m_poff[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err_empty", err_empty, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);

    // Empty template straight after reset
    do_req(7'd3, 12'h0, 0, 1'b0, 8'h0);

    // Basic two-word template, then with a stall on the second word
    cfg_write(1'b0, 8'h00, 32'hE52D0004);
    cfg_write(1'b0, 8'h01, 32'hE49D0004);
    cfg_write(1'b1, 8'd5, desc(8'h00, 4'd2, 1'b0, 4'd0));
    do_req(7'd5, 12'h0, 0, 1'b0, 8'h0);
    do_req(7'd5, 12'h0, 2, 1'b0, 8'h0);

    // Address wrap-around
    cfg_write(1'b0, 8'hFF, 32'hE1A00000);
    cfg_write(1'b1, 8'd7, desc(8'hFF, 4'd3, 1'b0, 4'd0));
    do_req(7'd7, 12'h0, 0, 1'b0, 8'h0);

    // Config write while busy is dropped; store re-read unchanged
    do_req(7'd7, 12'h0, 0, 1'b1, 8'h00);
    do_req(7'd5, 12'h0, 0, 1'b0, 8'h0);

    // Immediate patch on word 0
    cfg_write(1'b0, 8'h10, 32'hE3A00000);
    cfg_write(1'b1, 8'd9, desc(8'h10, 4'd1, 1'b1, 4'd0));
    do_req(7'd9, 12'h07F, 0, 1'b0, 8'h0);
`ifdef JIT_EMIT_PATCH_EN
    check("patch_model_word", m_word[8'h10] | 32'h07F, 32'hE3A0007F);
`endif

    // Randomized store, descriptors and requests
    for (int a = 32; a < 256; a++) begin
      cfg_write(1'b0, 8'(a), $urandom());
    end
    for (int i = 10; i < 30; i++) begin
      cfg_write(1'b1, 8'(i), desc(8'($urandom_range(32, 255)), 4'($urandom_range(0, 15)),
                                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15))));
    end
    for (int r = 0; r < 30; r++) begin
      do_req(7'($urandom_range(10, 29)), 12'($urandom()), 1, 1'b0, 8'h0);
    end
    // Maximum-length template with random stalls
    cfg_write(1'b1, 8'd40, desc(8'hF8, 4'd15, 1'b1, 4'd14));
    do_req(7'd40, 12'hABC, 1, 1'b0, 8'h0);

    // Reset in the middle of a stream
    req_valid = 1'b1; req_idx = 7'd5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_abort_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_last", out_last, 0);
    check("abort_req_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 128; i++) m_len[i] = '0;
    @(negedge clk);
    check("after_abort_req_ready", req_ready, 1);
    do_req(7'd5, 12'h0, 0, 1'b0, 8'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end
endmodule
